// File: rtl/packet_endpoint.sv
// NoC port endpoint: a packet source driving 4-phase req/ack flits with LFSR-chosen
// destinations, and an independent sink that acknowledges and counts incoming flits.
module packet_endpoint #(
  parameter int ID        = 0,
  parameter int FLITS     = 8,
  parameter int SIZE      = 8,
  parameter int SEED      = 5,
  parameter int PACKETS   = 1,
  parameter int PORT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 src_req,
  input  logic                 src_ack,
  output logic [SIZE-1:0]      src_data,
  output logic                 src_done,
  input  logic                 snk_req,
  input  logic [SIZE-1:0]      snk_data,
  output logic                 snk_ack,
  output logic [15:0]          snk_flits,
  output logic [15:0]          snk_packets,
  output logic [SIZE-2:0]      snk_last_dest,
  output logic [PORT_BITS-1:0] snk_id,
  output logic [2:0]           src_state_dbg
);

  // Handshake (both channels, 4-phase): the sender makes data stable, then raises req;
  // the receiver raises ack once it has taken the data; the sender drops req; the
  // receiver drops ack. Data may change only after ack has fallen.

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DRIVE       = 3'd1,
    S_WAIT_ACK_HI = 3'd2,
    S_WAIT_ACK_LO = 3'd3,
    S_DONE        = 3'd4
  } src_state_t;

  localparam int FW = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int PW = (PACKETS > 1) ? $clog2(PACKETS) : 1;
  localparam logic [FW-1:0]   LAST_FLIT = FW'(FLITS - 1);
  localparam logic [PW-1:0]   LAST_PKT  = PW'((PACKETS > 0) ? PACKETS - 1 : 0);
  localparam logic [15:0]     SEED_16   = 16'(SEED);
  localparam logic [15:0]     LFSR_INIT = (SEED_16 == 16'd0) ? 16'd1 : SEED_16;
  localparam logic [15:0]     LFSR_MASK = 16'hB400;
  localparam logic [SIZE-2:0] BODY_BASE = (SIZE-1)'(ID * FLITS);

  src_state_t       state;
  src_state_t       state_next;
  logic             launch;
  logic [FW-1:0]    flit_cnt;
  logic [FW-1:0]    next_idx;
  logic [PW-1:0]    pkt_cnt;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic             last_flit;
  logic             last_pkt;
  logic [SIZE-2:0]  body_low;
  logic [SIZE-2:0]  dest;
  logic [SIZE-1:0]  flit_word;
  logic             expect_head;

  // ---------------- source FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  assign last_flit = (flit_cnt == LAST_FLIT);
  assign last_pkt  = (pkt_cnt == LAST_PKT);

  // ---------------- source FSM: next state ----------------
  // launch marks the edge that loads a new flit into src_data (entry into DRIVE).
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (PACKETS > 0) begin
          state_next = S_DRIVE;
          launch     = 1'b1;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DRIVE:       state_next = S_WAIT_ACK_HI;
      S_WAIT_ACK_HI: if (src_ack) state_next = S_WAIT_ACK_LO;
      S_WAIT_ACK_LO: begin
        if (!src_ack) begin
          if (last_flit && last_pkt) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DRIVE;
            launch     = 1'b1;
          end
        end
      end
      S_DONE:        state_next = S_DONE;
      default:       state_next = S_IDLE;
    endcase
  end

  // ---------------- source FSM: outputs ----------------
  always_comb begin
    src_req       = (state == S_WAIT_ACK_HI);
    src_done      = (state == S_DONE);
    src_state_dbg = state;
  end

  // ---------------- source datapath ----------------
  assign next_idx  = ((state == S_IDLE) || last_flit) ? '0 : flit_cnt + FW'(1);
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'd0);
  assign dest      = (SIZE-1)'(lfsr);
  assign body_low  = BODY_BASE + (SIZE-1)'(next_idx);
  assign flit_word = {(next_idx == LAST_FLIT), (next_idx == '0) ? dest : body_low};

  // The destination is taken from the LFSR before it steps for this head flit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_data <= '0;
      flit_cnt <= '0;
      pkt_cnt  <= '0;
      lfsr     <= LFSR_INIT;
    end else if (launch) begin
      src_data <= flit_word;
      flit_cnt <= next_idx;
      if (next_idx == '0) begin
        lfsr <= lfsr_next;
        if (state != S_IDLE) pkt_cnt <= pkt_cnt + PW'(1);
      end
    end
  end

  // ---------------- sink ----------------
  // expect_head is set after reset and after every tail, so the next capture is a head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snk_ack       <= 1'b0;
      snk_flits     <= '0;
      snk_packets   <= '0;
      snk_last_dest <= '0;
      expect_head   <= 1'b1;
    end else if (snk_req && !snk_ack) begin
      snk_ack     <= 1'b1;
      snk_flits   <= snk_flits + 16'd1;
      expect_head <= snk_data[SIZE-1];
      if (snk_data[SIZE-1]) snk_packets <= snk_packets + 16'd1;
      if (expect_head)      snk_last_dest <= snk_data[SIZE-2:0];
    end else if (!snk_req && snk_ack) begin
      snk_ack <= 1'b0;
    end
  end

  assign snk_id = PORT_BITS'(ID);

endmodule

// File: tb/tb_packet_endpoint.sv
// Bench for packet_endpoint: three instances (default, 3 packets, 0 packets) driven by
// randomized ack responders and a randomized sink feeder, checked against a flit model.
module tb_packet_endpoint;

  localparam int SIZE  = 8;
  localparam int FLITS = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance a: defaults
  logic            a_src_req, a_src_ack, a_src_done, a_snk_req, a_snk_ack;
  logic [SIZE-1:0] a_src_data, a_snk_data;
  logic [15:0]     a_snk_flits, a_snk_packets;
  logic [SIZE-2:0] a_snk_last_dest;
  logic [7:0]      a_snk_id;
  logic [2:0]      a_dbg;
  // instance b: ID=3, PACKETS=3, PORT_BITS=4
  logic            b_src_req, b_src_ack, b_src_done, b_snk_ack;
  logic            b_snk_req = 1'b0;
  logic [SIZE-1:0] b_src_data;
  logic [SIZE-1:0] b_snk_data = '0;
  logic [15:0]     b_snk_flits, b_snk_packets;
  logic [SIZE-2:0] b_snk_last_dest;
  logic [3:0]      b_snk_id;
  logic [2:0]      b_dbg;
  // instance c: ID=300, PACKETS=0
  logic            c_src_req, c_src_done, c_snk_ack;
  logic            c_src_ack = 1'b0;
  logic            c_snk_req = 1'b0;
  logic [SIZE-1:0] c_src_data;
  logic [SIZE-1:0] c_snk_data = '0;
  logic [15:0]     c_snk_flits, c_snk_packets;
  logic [SIZE-2:0] c_snk_last_dest;
  logic [7:0]      c_snk_id;
  logic [2:0]      c_dbg;

  packet_endpoint u_a (
    .clk(clk), .reset(reset), .src_req(a_src_req), .src_ack(a_src_ack), .src_data(a_src_data),
    .src_done(a_src_done), .snk_req(a_snk_req), .snk_data(a_snk_data), .snk_ack(a_snk_ack),
    .snk_flits(a_snk_flits), .snk_packets(a_snk_packets), .snk_last_dest(a_snk_last_dest),
    .snk_id(a_snk_id), .src_state_dbg(a_dbg)
  );

  packet_endpoint #(.ID(3), .PACKETS(3), .PORT_BITS(4)) u_b (
    .clk(clk), .reset(reset), .src_req(b_src_req), .src_ack(b_src_ack), .src_data(b_src_data),
    .src_done(b_src_done), .snk_req(b_snk_req), .snk_data(b_snk_data), .snk_ack(b_snk_ack),
    .snk_flits(b_snk_flits), .snk_packets(b_snk_packets), .snk_last_dest(b_snk_last_dest),
    .snk_id(b_snk_id), .src_state_dbg(b_dbg)
  );

  packet_endpoint #(.ID(300), .PACKETS(0)) u_c (
    .clk(clk), .reset(reset), .src_req(c_src_req), .src_ack(c_src_ack), .src_data(c_src_data),
    .src_done(c_src_done), .snk_req(c_snk_req), .snk_data(c_snk_data), .snk_ack(c_snk_ack),
    .snk_flits(c_snk_flits), .snk_packets(c_snk_packets), .snk_last_dest(c_snk_last_dest),
    .snk_id(c_snk_id), .src_state_dbg(c_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [SIZE-1:0] exp_q[$];
  logic [SIZE-1:0] exp_q3[$];
  int              m_flits, m_pkts;
  logic [SIZE-2:0] m_dest;
  bit              m_head;
  bit              c_req_seen = 1'b0;

  always @(negedge clk) if (c_src_req === 1'b1) c_req_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  task automatic build_exp(input int p, input int id, input int seed, input int packets);
    logic [15:0]     s;
    logic [SIZE-2:0] dest;
    logic [SIZE-1:0] w;
    s = (seed == 0) ? 16'd1 : 16'(seed);
    for (int pk = 0; pk < packets; pk++) begin
      dest = s[SIZE-2:0];
      s = lfsr_step(s);
      for (int k = 0; k < FLITS; k++) begin
        w[SIZE-1]   = (k == FLITS - 1);
        w[SIZE-2:0] = (k == 0) ? dest : 7'((id * FLITS + k) % 128);
        if (p == 0) exp_q.push_back(w);
        else        exp_q3.push_back(w);
      end
    end
  endtask

  function automatic logic [SIZE-1:0] pop_exp(input int p);
    if (p == 0) return (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    return (exp_q3.size() > 0) ? exp_q3.pop_front() : 'x;
  endfunction

  function automatic logic get_req(input int p);
    return (p == 0) ? a_src_req : b_src_req;
  endfunction

  function automatic logic get_done(input int p);
    return (p == 0) ? a_src_done : b_src_done;
  endfunction

  function automatic logic [SIZE-1:0] get_data(input int p);
    return (p == 0) ? a_src_data : b_src_data;
  endfunction

  task automatic set_ack(input int p, input logic v);
    if (p == 0) a_src_ack = v;
    else        b_src_ack = v;
  endtask

  task automatic model_sink_reset();
    m_flits = 0; m_pkts = 0; m_dest = '0; m_head = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic serve(input int p, input int n, input bit final_at_end, input int hold_at);
    logic [SIZE-1:0] exp, prev, held;
    int t;
    bit ok;
    for (int i = 0; i < n; i++) begin
      t = 0;
      prev = get_data(p);
      while (get_req(p) !== 1'b1 && t < 200) begin
        prev = get_data(p);
        @(negedge clk);
        t++;
      end
      check($sformatf("p%0d_req_rise_%0d", p, i), 32'(get_req(p)), 32'd1);
      if (get_req(p) !== 1'b1) return;
      exp = pop_exp(p);
      check($sformatf("p%0d_data_%0d", p, i), 32'(get_data(p)), 32'(exp));
      check($sformatf("p%0d_data_setup_%0d", p, i), 32'(get_data(p)), 32'(prev));
      check($sformatf("p%0d_done_early_%0d", p, i), 32'(get_done(p)), 32'd0);
      if (i == hold_at) begin
        ok = 1'b1;
        held = get_data(p);
        repeat (20) begin
          @(negedge clk);
          if (get_req(p) !== 1'b1 || get_data(p) !== held) ok = 1'b0;
        end
        check($sformatf("p%0d_hold_stable_%0d", p, i), 32'(ok), 32'd1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      set_ack(p, 1'b1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (get_req(p) !== 1'b0 && t < 200);
      check($sformatf("p%0d_req_fall_%0d", p, i), 32'(get_req(p)), 32'd0);
      check($sformatf("p%0d_data_held_%0d", p, i), 32'(get_data(p)), 32'(exp));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      set_ack(p, 1'b0);
      @(negedge clk);
      check($sformatf("p%0d_done_after_%0d", p, i), 32'(get_done(p)),
            32'(final_at_end && (i == n - 1)));
    end
  endtask

  task automatic model_capture(input logic [SIZE-1:0] d);
    m_flits++;
    if (d[SIZE-1]) m_pkts++;
    if (m_head) m_dest = d[SIZE-2:0];
    m_head = d[SIZE-1];
  endtask

  task automatic sink_flit(input logic [SIZE-1:0] d);
    a_snk_data = d;
    @(negedge clk);
    a_snk_req = 1'b1;
    @(negedge clk);
    check("snk_ack_rise", 32'(a_snk_ack), 32'd1);
    model_capture(d);
    a_snk_req = 1'b0;
    @(negedge clk);
    check("snk_ack_fall", 32'(a_snk_ack), 32'd0);
  endtask

  task automatic sink_counters(input string tag);
    check({tag, "_flits"}, 32'(a_snk_flits), 32'(m_flits));
    check({tag, "_packets"}, 32'(a_snk_packets), 32'(m_pkts));
    check({tag, "_last_dest"}, 32'(a_snk_last_dest), 32'(m_dest));
  endtask

  task automatic sink_run();
    logic [SIZE-1:0] d;
    for (int i = 0; i < 16; i++) begin
      d = {1'b0, 7'($urandom_range(0, 127))};
      if (i == 0) d = 8'h03;
      if (i == 8) d = 8'h55;
      if (i == 7 || i == 15) d[SIZE-1] = 1'b1;
      sink_flit(d);
    end
    sink_counters("snk_directed");
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      d[SIZE-1] = ($urandom_range(0, 3) == 0);
      sink_flit(d);
    end
    sink_counters("snk_random");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    a_src_ack = 1'b0; b_src_ack = 1'b0; a_snk_req = 1'b0; a_snk_data = '0;
    model_sink_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_src_req", 32'(a_src_req), 32'd0);
    check("rst_src_data", 32'(a_src_data), 32'd0);
    check("rst_src_done", 32'(a_src_done), 32'd0);
    check("rst_c_src_done", 32'(c_src_done), 32'd0);
    check("rst_snk_ack", 32'(a_snk_ack), 32'd0);
    sink_counters("rst");
    check("snk_id_a", 32'(a_snk_id), 32'd0);
    check("snk_id_b", 32'(b_snk_id), 32'd3);
    check("snk_id_c", 32'(c_snk_id), 32'(300 % 256));

    build_exp(0, 0, 5, 1);
    build_exp(1, 3, 5, 3);
    reset = 1'b0;
    @(negedge clk);
    check("c_done_after_release", 32'(c_src_done), 32'd1);

    fork
      serve(0, 8, 1'b1, 2);
      serve(1, 24, 1'b1, -1);
      sink_run();
    join

    check("b_queue_drained", 32'(exp_q3.size()), 32'd0);
    check("c_done_still", 32'(c_src_done), 32'd1);

    // reset during flit 4 of a fresh packet, with the sink mid-handshake
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_sink_reset();
    exp_q.delete();
    build_exp(0, 0, 5, 1);
    serve(0, 4, 1'b0, -1);
    a_snk_data = 8'h83;
    @(negedge clk);
    a_snk_req = 1'b1;
    @(negedge clk);
    check("mid_snk_ack", 32'(a_snk_ack), 32'd1);
    model_capture(8'h83);
    sink_counters("mid");
    t = 0;
    while (a_src_req !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid_flit4_req", 32'(a_src_req), 32'd1);
    reset = 1'b1;
    #1;
    model_sink_reset();
    check("async_src_req", 32'(a_src_req), 32'd0);
    check("async_src_data", 32'(a_src_data), 32'd0);
    check("async_snk_ack", 32'(a_snk_ack), 32'd0);
    check("async_c_done", 32'(c_src_done), 32'd0);
    sink_counters("async");
    a_snk_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    build_exp(0, 0, 5, 1);
    @(negedge clk);
    check("c_done_after_rerelease", 32'(c_src_done), 32'd1);
    serve(0, 8, 1'b1, -1);
    sink_counters("post_reset");

    check("c_req_never", 32'(c_req_seen), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
